// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single data-memory port: round-robin between the
// CPU load/store unit (port 0) and the debug/DMA loader (port 1), with lock support.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module dmem_arbiter #(
  parameter int W       = `WORD_WIDTH,
  parameter int ADDR_HI = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic         we0,
  input  logic         we1,
  input  logic         lock0,
  input  logic         lock1,
  input  logic [W-1:0] addr0,
  input  logic [W-1:0] addr1,
  input  logic [W-1:0] wdata0,
  input  logic [W-1:0] wdata1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         err0,
  output logic         err1,
  output logic         rvalid0,
  output logic         rvalid1,
  output logic [W-1:0] rdata0,
  output logic [W-1:0] rdata1,
  output logic         mem_read_en,
  output logic [W-1:0] mem_read_addr,
  input  logic [W-1:0] mem_read_data,
  output logic         mem_write_en,
  output logic [W-1:0] mem_write_addr,
  output logic [W-1:0] mem_write_data,
  output logic [1:0]   dbg_state,
  output logic         dbg_last_grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  // Handshake: reqN/weN/lockN/addrN/wdataN are held by the requester until
  // gntN; gntN is a one-cycle pulse marking the cycle the access is performed.

  // Only the address bits the memory decodes are forwarded.
  localparam logic [W-1:0] ADDR_MASK = {{(W-ADDR_HI-1){1'b0}}, {(ADDR_HI+1){1'b1}}};

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic           mis0, mis1, acc0, acc1;

  always_comb begin
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    mem_read_en    = 1'b0;
    mem_read_addr  = '0;
    mem_write_en   = 1'b0;
    mem_write_addr = '0;
    mem_write_data = '0;

    unique case (state_q)
      IDLE: begin
        // On a tie the port that was not granted last wins.
        if (req0 && (!req1 || last_grant_q)) gnt0 = 1'b1;
        else if (req1)                       gnt1 = 1'b1;
      end
      LOCK0:   gnt0 = req0;
      LOCK1:   gnt1 = req1;
      default: state_d = IDLE;
    endcase

    mis0 = (addr0[1:0] != 2'b00);
    mis1 = (addr1[1:0] != 2'b00);
    err0 = gnt0 & mis0;
    err1 = gnt1 & mis1;
    acc0 = gnt0 & ~mis0;
    acc1 = gnt1 & ~mis1;

    if (acc0) begin
      mem_read_en    = ~we0;
      mem_read_addr  = we0 ? '0 : (addr0 & ADDR_MASK);
      mem_write_en   = we0;
      mem_write_addr = we0 ? (addr0 & ADDR_MASK) : '0;
      mem_write_data = we0 ? wdata0 : '0;
    end else if (acc1) begin
      mem_read_en    = ~we1;
      mem_read_addr  = we1 ? '0 : (addr1 & ADDR_MASK);
      mem_write_en   = we1;
      mem_write_addr = we1 ? (addr1 & ADDR_MASK) : '0;
      mem_write_data = we1 ? wdata1 : '0;
    end

    // Misaligned grants still update ownership and fairness.
    if (gnt0) begin
      state_d      = lock0 ? LOCK0 : IDLE;
      last_grant_d = 1'b0;
    end else if (gnt1) begin
      state_d      = lock1 ? LOCK1 : IDLE;
      last_grant_d = 1'b1;
    end

    rvalid0_d = acc0 & ~we0;
    rvalid1_d = acc1 & ~we1;
    rdata0_d  = rvalid0_d ? mem_read_data : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_read_data : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign rvalid0        = rvalid0_q;
  assign rvalid1        = rvalid1_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;
  assign dbg_state      = state_q;
  assign dbg_last_grant = last_grant_q;

endmodule
